// File: rtl/simple_uart_tx_buffer_pkg.sv
// Shared constants, FSM state encoding and frame-timing helpers for the UART TX buffer.
package simple_uart_tx_buffer_pkg;

    // Start bit + 8 data bits + stop bit.
    localparam int UART_FRAME_BITS = 10;

    // Pacer FSM states.
    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SPACE = 1'b1
    } pacer_state_t;

    // Clocks per UART bit, using the same integer division as simple_uart.
    function automatic int calc_clks_per_bit(input int system_freq, input int baud_rate);
        return system_freq / baud_rate;
    endfunction

    // Clocks reserved for one frame, including the idle guard clocks.
    function automatic int calc_frame_clks(input int system_freq, input int baud_rate,
                                           input int guard_clks);
        return UART_FRAME_BITS * calc_clks_per_bit(system_freq, baud_rate) + guard_clks;
    endfunction

endpackage

// File: rtl/simple_uart_sync_fifo.sv
// Synchronous byte FIFO with extra-MSB pointers for full/empty detection.
module simple_uart_sync_fifo #(
    parameter int WIDTH      = 8,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clock,
    input  logic                  srst,
    input  logic [WIDTH-1:0]      wr_data,
    input  logic                  wr_en,
    output logic [WIDTH-1:0]      rd_data,
    input  logic                  rd_en,
    output logic                  full,
    output logic                  empty,
    output logic [DEPTH_LOG2:0]   level
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [WIDTH-1:0]    mem [DEPTH];
    logic [DEPTH_LOG2:0] wr_ptr;
    logic [DEPTH_LOG2:0] rd_ptr;
    logic                push;
    logic                pop;

    // Writes are blocked when full and reads when empty, so callers may assert freely.
    assign push = wr_en & ~full;
    assign pop  = rd_en & ~empty;

    // Equal pointers mean empty; differing only in the MSB means full.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[DEPTH_LOG2] != rd_ptr[DEPTH_LOG2]) &&
                   (wr_ptr[DEPTH_LOG2-1:0] == rd_ptr[DEPTH_LOG2-1:0]);
    assign level = wr_ptr - rd_ptr;

    // Head of queue read straight from the array; no bypass of a same-edge write.
    assign rd_data = mem[rd_ptr[DEPTH_LOG2-1:0]];

    // Pointer advance; pointers wrap naturally modulo 2**(DEPTH_LOG2+1).
    always_ff @(posedge clock or posedge srst) begin
        if (srst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage array holds data only, so it carries no reset.
    always_ff @(posedge clock) begin
        if (push) mem[wr_ptr[DEPTH_LOG2-1:0]] <= wr_data;
    end

endmodule

// File: rtl/simple_uart_tx_buffer.sv
// Byte FIFO plus frame pacer feeding simple_uart's TX port, one write per frame slot.
module simple_uart_tx_buffer
    import simple_uart_tx_buffer_pkg::*;
#(
    parameter int SYSTEM_FREQ = 50_000_000,
    parameter int BAUD_RATE   = 9600,
    parameter int DEPTH_LOG2  = 4,
    parameter int GUARD_CLKS  = 2
) (
    input  logic                  clock,
    input  logic                  srst,
    input  logic [7:0]            in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [DEPTH_LOG2:0]   fifo_level,
    output logic [7:0]            tx_value,
    output logic                  tx_value_write
);

    localparam int FRAME_CLKS = calc_frame_clks(SYSTEM_FREQ, BAUD_RATE, GUARD_CLKS);
    localparam int CNT_W      = (FRAME_CLKS > 2) ? $clog2(FRAME_CLKS) : 1;
    localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(FRAME_CLKS - 1);

    pacer_state_t     state;
    logic [CNT_W-1:0] space_cnt;
    logic             ready_q;
    logic             fifo_full;
    logic             fifo_empty;
    logic             fifo_rd_en;
    logic [7:0]       fifo_rd_data;

    // Hold ready low until the first edge after reset release.
    assign in_ready = ready_q & ~fifo_full;

    // Pop only from IDLE; the FSM loads the head into tx_value on that same edge.
    assign fifo_rd_en = (state == ST_IDLE) & ~fifo_empty;

    simple_uart_sync_fifo #(
        .WIDTH      (8),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_fifo (
        .clock   (clock),
        .srst    (srst),
        .wr_data (in_data),
        .wr_en   (in_valid & ready_q),
        .rd_data (fifo_rd_data),
        .rd_en   (fifo_rd_en),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (fifo_level)
    );

    // Ready-enable flag: set on the first clock edge after reset is released.
    always_ff @(posedge clock or posedge srst) begin
        if (srst) ready_q <= 1'b0;
        else      ready_q <= 1'b1;
    end

    // Pacer: issue one write pulse, then wait FRAME_CLKS edges before the next pop.
    always_ff @(posedge clock or posedge srst) begin
        if (srst) begin
            state          <= ST_IDLE;
            space_cnt      <= '0;
            tx_value       <= 8'h00;
            tx_value_write <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (!fifo_empty) begin
                        tx_value       <= fifo_rd_data;
                        tx_value_write <= 1'b1;
                        space_cnt      <= CNT_RELOAD;
                        state          <= ST_SPACE;
                    end else begin
                        tx_value_write <= 1'b0;
                    end
                end
                ST_SPACE: begin
                    tx_value_write <= 1'b0;
                    if (space_cnt == '0) state     <= ST_IDLE;
                    else                 space_cnt <= space_cnt - 1'b1;
                end
                default: begin
                    tx_value_write <= 1'b0;
                    state          <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_simple_uart_tx_buffer.sv
// Randomized bench for simple_uart_tx_buffer against a queue-and-countdown reference model.
module tb_simple_uart_tx_buffer;

    localparam int SYSTEM_FREQ = 1_000_000;
    localparam int BAUD_RATE   = 100_000;
    localparam int DEPTH_LOG2  = 2;
    localparam int GUARD_CLKS  = 2;
    localparam int DEPTH       = 1 << DEPTH_LOG2;
    localparam int FRAME       = 10 * (SYSTEM_FREQ / BAUD_RATE) + GUARD_CLKS;

    logic                clock;
    logic                srst;
    logic [7:0]          in_data;
    logic                in_valid;
    logic                in_ready;
    logic [DEPTH_LOG2:0] fifo_level;
    logic [7:0]          tx_value;
    logic                tx_value_write;

    int errors = 0;
    int checks = 0;

    // Reference model state
    logic [7:0] q_m[$];
    int         busy_m;
    logic [7:0] last_m;
    bit         wr_m;
    bit         init_m;
    longint     edge_cnt;
    longint     last_pulse;
    int         pulses;

    simple_uart_tx_buffer #(
        .SYSTEM_FREQ (SYSTEM_FREQ),
        .BAUD_RATE   (BAUD_RATE),
        .DEPTH_LOG2  (DEPTH_LOG2),
        .GUARD_CLKS  (GUARD_CLKS)
    ) dut (
        .clock          (clock),
        .srst           (srst),
        .in_data        (in_data),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .fifo_level     (fifo_level),
        .tx_value       (tx_value),
        .tx_value_write (tx_value_write)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, act, exp, edge_cnt);
        end
    endtask

    function automatic bit model_ready();
        return init_m && (q_m.size() < DEPTH);
    endfunction

    task automatic model_reset();
        q_m.delete();
        busy_m     = 0;
        last_m     = 8'h00;
        wr_m       = 0;
        init_m     = 0;
        last_pulse = -1;
    endtask

    task automatic check_outputs();
        check_val("tx_value_write", {31'd0, tx_value_write}, {31'd0, wr_m});
        check_val("tx_value", {24'd0, tx_value}, {24'd0, last_m});
        check_val("fifo_level", 32'(fifo_level), 32'(q_m.size()));
        check_val("in_ready", {31'd0, in_ready}, {31'd0, model_ready()});
    endtask

    // One clock: drive at negedge, update model at posedge, check at next negedge.
    task automatic cycle(input logic v, input logic [7:0] d);
        bit push;
        bit pop;
        in_valid = v;
        in_data  = d;
        @(posedge clock);
        edge_cnt++;
        pop  = (busy_m == 0) && (q_m.size() > 0);
        push = v && model_ready();
        if (pop) begin
            last_m = q_m.pop_front();
            wr_m   = 1;
            busy_m = FRAME;
        end else begin
            wr_m = 0;
            if (busy_m > 0) busy_m--;
        end
        if (push) q_m.push_back(d);
        init_m = 1;
        @(negedge clock);
        check_outputs();
        if (tx_value_write) begin
            pulses++;
            if (last_pulse >= 0)
                check_val("pulse_spacing", {31'd0, (edge_cnt - last_pulse) >= FRAME + 1}, 32'd1);
            last_pulse = edge_cnt;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 8'h00);
    endtask

    // Present bytes start..start+n-1 with valid held until each one is accepted.
    task automatic send_stream(input logic [7:0] start, input int n, input int budget);
        int idx = 0;
        int cyc = 0;
        while (idx < n && cyc < budget) begin
            bit acc;
            acc = model_ready();
            cycle(1'b1, start + 8'(idx));
            if (acc) idx++;
            cyc++;
        end
        check_val("stream_accepted", 32'(idx), 32'(n));
    endtask

    initial begin
        int pulses_before;
        srst     = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;
        edge_cnt = 0;
        pulses   = 0;
        model_reset();
        repeat (3) @(negedge clock);
        check_outputs();
        srst = 1'b0;

        // Single byte
        idle(5);
        pulses_before = pulses;
        cycle(1'b1, 8'hA5);
        idle(110);
        check_val("single_pulses", 32'(pulses - pulses_before), 32'd1);

        // Burst of four
        pulses_before = pulses;
        send_stream(8'h01, 4, 50);
        idle(4 * (FRAME + 1) + 10);
        check_val("burst_pulses", 32'(pulses - pulses_before), 32'd4);

        // Full back-pressure with six bytes
        pulses_before = pulses;
        send_stream(8'h40, 6, 1000);
        idle(6 * (FRAME + 1) + 10);
        check_val("bp_pulses", 32'(pulses - pulses_before), 32'd6);

        // Pointer wrap with twenty bytes
        pulses_before = pulses;
        send_stream(8'h00, 20, 3000);
        idle(5 * (FRAME + 1) + 10);
        check_val("wrap_pulses", 32'(pulses - pulses_before), 32'd20);
        check_val("wrap_final_level", 32'(fifo_level), 32'd0);

        // Async reset mid-SPACE with three bytes queued
        send_stream(8'hC0, 4, 50);
        idle(20);
        check_val("pre_reset_queued", 32'(q_m.size()), 32'd3);
        #2;
        srst = 1'b1;
        #1;
        model_reset();
        check_outputs();
        in_valid = 1'b0;
        @(negedge clock);
        check_outputs();
        srst = 1'b0;
        cycle(1'b0, 8'h00);
        check_val("post_reset_ready", {31'd0, in_ready}, 32'd1);
        pulses_before = pulses;
        idle(150);
        check_val("post_reset_pulses", 32'(pulses - pulses_before), 32'd0);

        // Randomized traffic with varying load
        for (int blk = 0; blk < 8; blk++) begin
            int pct;
            pct = $urandom_range(1, 100);
            for (int i = 0; i < 500; i++)
                cycle($urandom_range(0, 99) < pct, 8'($urandom));
        end
        idle((DEPTH + 1) * (FRAME + 1) + 10);
        check_val("final_level", 32'(fifo_level), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
